// File: rtl/code_entry_controller.sv
// ---------------------------------------------------------------------------
// code_entry_controller
//
// Runs one passcode attempt: arms the button receiver, waits for four
// presses, compares them digit-serially against the secret code and reports
// unlock/deny.
//
// In the default build the comparison stops at the first mismatch, and every
// digit takes DIGIT_DELAY_CYCLES cycles. The time spent checking therefore
// reveals how many leading digits were correct.
//
// MAX_FAILS consecutive failures put the block into a timed lockout.
//
// Build option:
//   CONSTANT_TIME_COMPARE_EN - when defined, all four digits are always
//   compared. match_count then reports the total number of matching digits.
//   The verdict is issued after digit 3.
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   start        one-cycle request for a new attempt (honoured in IDLE only)
//   code[7:0]    secret code, digit i = code[2i+1:2i]
//   rx_done      receiver has collected four presses
//   rx_btns[7:0] receiver presses, press i = rx_btns[2i+1:2i]
//   rx_restart   one-cycle pulse clearing the receiver
//   busy         high in every state except IDLE
//   unlocked     last attempt matched
//   denied       last attempt failed (held through lockout)
//   locked_out   high while in lockout
//   match_count  digits matched in the last check
//   fail_count   consecutive failed attempts
// ---------------------------------------------------------------------------
module code_entry_controller #(
    parameter int unsigned DIGIT_DELAY_CYCLES = 25_000_000,
    parameter int unsigned MAX_FAILS          = 3,
    parameter int unsigned LOCKOUT_CYCLES     = 500_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] code,
    input  logic       rx_done,
    input  logic [7:0] rx_btns,
    output logic       rx_restart,
    output logic       busy,
    output logic       unlocked,
    output logic       denied,
    output logic       locked_out,
    output logic [2:0] match_count,
    output logic [3:0] fail_count
);

    localparam int unsigned DelayW = (DIGIT_DELAY_CYCLES > 1) ? $clog2(DIGIT_DELAY_CYCLES) : 1;
    localparam int unsigned LockW  = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [DelayW-1:0] DelayLast = DelayW'(DIGIT_DELAY_CYCLES - 1);
    localparam logic [LockW-1:0]  LockLast  = LockW'(LOCKOUT_CYCLES - 1);
    localparam logic [3:0]        MaxFails  = 4'(MAX_FAILS);

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StCollect,
        StCheck,
        StLockout
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        code_q, code_d;
    logic [7:0]        entry_q, entry_d;
    logic [1:0]        digit_q, digit_d;
    logic [DelayW-1:0] delay_q, delay_d;
    logic [LockW-1:0]  lock_q, lock_d;
    logic              unlocked_q, unlocked_d;
    logic              denied_q, denied_d;
    logic [2:0]        match_q, match_d;
    logic [3:0]        fail_q, fail_d;

    logic              digit_ok;
    logic              verdict_pass;
    logic              verdict_fail;
    logic [3:0]        fail_inc;
`ifdef CONSTANT_TIME_COMPARE_EN
    logic [2:0]        match_acc;
`endif

    // The reserved value 2'b11 never matches, on either side.
    function automatic logic digit_match(input logic [7:0] a, input logic [7:0] b,
                                         input logic [1:0] k);
        logic [1:0] da;
        logic [1:0] db;
        da = a[{k, 1'b0} +: 2];
        db = b[{k, 1'b0} +: 2];
        return (da == db) && (da != 2'b11) && (db != 2'b11);
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            code_q     <= '0;
            entry_q    <= '0;
            digit_q    <= '0;
            delay_q    <= '0;
            lock_q     <= '0;
            unlocked_q <= 1'b0;
            denied_q   <= 1'b0;
            match_q    <= '0;
            fail_q     <= '0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            entry_q    <= entry_d;
            digit_q    <= digit_d;
            delay_q    <= delay_d;
            lock_q     <= lock_d;
            unlocked_q <= unlocked_d;
            denied_q   <= denied_d;
            match_q    <= match_d;
            fail_q     <= fail_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        code_d       = code_q;
        entry_d      = entry_q;
        digit_d      = digit_q;
        delay_d      = delay_q;
        lock_d       = lock_q;
        unlocked_d   = unlocked_q;
        denied_d     = denied_q;
        match_d      = match_q;
        fail_d       = fail_q;
        verdict_pass = 1'b0;
        verdict_fail = 1'b0;
        digit_ok     = digit_match(entry_q, code_q, digit_q);
        fail_inc     = fail_q + 4'd1;
`ifdef CONSTANT_TIME_COMPARE_EN
        match_acc    = match_q + {2'b00, digit_ok};
`endif

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StArm;
                    code_d     = code;
                    unlocked_d = 1'b0;
                    denied_d   = 1'b0;
                    match_d    = '0;
                end
            end

            StArm: begin
                state_d = StCollect;
            end

            StCollect: begin
                if (rx_done) begin
                    entry_d = rx_btns;
                    digit_d = '0;
                    delay_d = '0;
                    state_d = StCheck;
                end
            end

            StCheck: begin
                if (delay_q == DelayLast) begin
                    delay_d = '0;
`ifdef CONSTANT_TIME_COMPARE_EN
                    // match_q was cleared on start, so it accumulates the total here.
                    match_d = match_acc;
                    if (digit_q != 2'd3) begin
                        digit_d = digit_q + 2'd1;
                    end else if (match_acc == 3'd4) begin
                        verdict_pass = 1'b1;
                    end else begin
                        verdict_fail = 1'b1;
                    end
`else
                    if (digit_ok) begin
                        if (digit_q == 2'd3) begin
                            verdict_pass = 1'b1;
                        end else begin
                            match_d = {1'b0, digit_q} + 3'd1;
                            digit_d = digit_q + 2'd1;
                        end
                    end else begin
                        match_d      = {1'b0, digit_q};
                        verdict_fail = 1'b1;
                    end
`endif
                end else begin
                    delay_d = delay_q + 1'b1;
                end

                if (verdict_pass) begin
                    match_d    = 3'd4;
                    unlocked_d = 1'b1;
                    fail_d     = '0;
                    state_d    = StIdle;
                end
                if (verdict_fail) begin
                    denied_d = 1'b1;
                    fail_d   = fail_inc;
                    lock_d   = '0;
                    state_d  = (fail_inc == MaxFails) ? StLockout : StIdle;
                end
            end

            StLockout: begin
                if (lock_q == LockLast) begin
                    fail_d   = '0;
                    denied_d = 1'b0;
                    state_d  = StIdle;
                end else begin
                    lock_d = lock_q + 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign rx_restart  = (state_q == StArm);
    assign busy        = (state_q != StIdle);
    assign locked_out  = (state_q == StLockout);
    assign unlocked    = unlocked_q;
    assign denied      = denied_q;
    assign match_count = match_q;
    assign fail_count  = fail_q;

endmodule

// File: tb/tb_code_entry_controller.sv
// ---------------------------------------------------------------------------
// tb_code_entry_controller
//
// The stimulus process pushes the expected outcome of each attempt onto a
// queue. The monitor then pops and checks that outcome when busy falls.
//
// The monitor also measures each attempt:
//   - busy length: ARM + COLLECT + CHECK + LOCKOUT
//   - rx_restart pulses
//   - lockout length
//
// D=4, MAX_FAILS=2, LOCKOUT_CYCLES=10.
// ---------------------------------------------------------------------------
module tb_code_entry_controller;

    localparam int D    = 4;
    localparam int LOCK = 10;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [7:0] code;
    logic       rx_done;
    logic [7:0] rx_btns;
    logic       rx_restart;
    logic       busy;
    logic       unlocked;
    logic       denied;
    logic       locked_out;
    logic [2:0] match_count;
    logic [3:0] fail_count;

    code_entry_controller #(
        .DIGIT_DELAY_CYCLES(D),
        .MAX_FAILS(2),
        .LOCKOUT_CYCLES(LOCK)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .code(code),
        .rx_done(rx_done),
        .rx_btns(rx_btns),
        .rx_restart(rx_restart),
        .busy(busy),
        .unlocked(unlocked),
        .denied(denied),
        .locked_out(locked_out),
        .match_count(match_count),
        .fail_count(fail_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unlocked;
        int denied;
        int match;
        int fails;
        int check_n;
        int lock_n;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    // ---------------- monitor ----------------
    int   busy_n;
    int   restart_n;
    int   restart_first;
    int   lock_n;
    int   lock_denied_n;
    bit   active = 1'b0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                active = 1'b0;
            end else if (busy) begin
                if (!active) begin
                    active        = 1'b1;
                    busy_n        = 0;
                    restart_n     = 0;
                    lock_n        = 0;
                    lock_denied_n = 0;
                    restart_first = int'(rx_restart);
                end
                busy_n++;
                if (rx_restart) restart_n++;
                if (locked_out) lock_n++;
                if (locked_out && denied) lock_denied_n++;
            end else if (active) begin
                active = 1'b0;
                if (sb_q.size() == 0) begin
                    chk("unexpected_attempt", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("busy_cycles", busy_n, 2 + e.check_n + e.lock_n);
                    chk("rx_restart_first", restart_first, 1);
                    chk("rx_restart_pulses", restart_n, 1);
                    chk("lockout_cycles", lock_n, e.lock_n);
                    chk("denied_in_lockout", lock_denied_n, e.lock_n);
                    chk("unlocked", int'(unlocked), e.unlocked);
                    chk("denied", int'(denied), e.denied);
                    chk("match_count", int'(match_count), e.match);
                    chk("fail_count", int'(fail_count), e.fails);
                    chk("locked_out_idle", int'(locked_out), 0);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    // Returns on the negedge after rx_done was taken; the DUT is then in CHECK.
    task automatic attempt(input logic [7:0] c, input logic [7:0] btns, input logic [7:0] c_late,
                           input bit push, input exp_t e);
        if (push) sb_q.push_back(e);
        @(negedge clk);
        code  = c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        code    = c_late;
        rx_btns = btns;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 reset_n = 1'b0;
        @(negedge clk);
        #2 reset_n = 1'b1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            chk("idle_timeout", 1, 0);
            pulse_reset();
        end
        repeat (2) @(negedge clk);
    endtask

    // Pulses start while locked out; it must not trigger a new attempt.
    task automatic poke_lockout();
        int n;
        n = 0;
        while (!locked_out && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("lockout_entered", int'(locked_out), 1);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_unlocked"}, int'(unlocked), 0);
        chk({tag, "_denied"}, int'(denied), 0);
        chk({tag, "_locked_out"}, int'(locked_out), 0);
        chk({tag, "_rx_restart"}, int'(rx_restart), 0);
        chk({tag, "_match"}, int'(match_count), 0);
        chk({tag, "_fails"}, int'(fail_count), 0);
    endtask

    function automatic exp_t mk(int u, int dn, int m, int f, int n, int l);
        exp_t e;
        e.unlocked = u;
        e.denied   = dn;
        e.match    = m;
        e.fails    = f;
        e.check_n  = n;
        e.lock_n   = l;
        return e;
    endfunction

    initial begin
        exp_t none;
        none    = mk(0, 0, 0, 0, 0, 0);
        reset_n = 1'b0;
        start   = 1'b0;
        code    = 8'h00;
        rx_done = 1'b0;
        rx_btns = 8'h00;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        #2 reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Correct code: full 4*D check.
        attempt(8'h24, 8'h24, 8'h24, 1'b1, mk(1, 0, 4, 0, 16, 0));
        wait_idle();

        // Digits 0,1 match and digit 2 differs (00 vs 10); digit 3 matches.
`ifdef CONSTANT_TIME_COMPARE_EN
        attempt(8'h24, 8'h04, 8'h24, 1'b1, mk(0, 1, 3, 1, 16, 0));
`else
        attempt(8'h24, 8'h04, 8'h24, 1'b1, mk(0, 1, 2, 1, 12, 0));
`endif
        wait_idle();

        // Second consecutive failure -> lockout; start during lockout ignored.
`ifdef CONSTANT_TIME_COMPARE_EN
        attempt(8'h24, 8'h00, 8'h24, 1'b1, mk(0, 0, 2, 0, 16, LOCK));
`else
        attempt(8'h24, 8'h00, 8'h24, 1'b1, mk(0, 0, 1, 0, 8, LOCK));
`endif
        poke_lockout();
        wait_idle();

        // Reserved digit 11 never matches, even against itself.
`ifdef CONSTANT_TIME_COMPARE_EN
        attempt(8'hFF, 8'hFF, 8'hFF, 1'b1, mk(0, 1, 0, 1, 16, 0));
`else
        attempt(8'hFF, 8'hFF, 8'hFF, 1'b1, mk(0, 1, 0, 1, 4, 0));
`endif
        wait_idle();

        // Code changes during COLLECT: the latched code is used.
        attempt(8'h24, 8'h24, 8'h00, 1'b1, mk(1, 0, 4, 0, 16, 0));
        wait_idle();

        // A failure that leaves fail_count and denied set before the reset test.
`ifdef CONSTANT_TIME_COMPARE_EN
        attempt(8'h24, 8'h00, 8'h24, 1'b1, mk(0, 1, 2, 1, 16, 0));
`else
        attempt(8'h24, 8'h00, 8'h24, 1'b1, mk(0, 1, 1, 1, 8, 0));
`endif
        wait_idle();

        // Reset mid-CHECK: everything returns to zero at once.
        attempt(8'h24, 8'h24, 8'h24, 1'b0, none);
        repeat (2) @(negedge clk);
        chk("busy_in_check", int'(busy), 1);
        #2 reset_n = 1'b0;
        #1 check_all_zero("midreset");
        @(negedge clk);
        #2 reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Normal attempts after reset, code 0x19 = digits 01,10,01,00.
        attempt(8'h19, 8'h19, 8'h19, 1'b1, mk(1, 0, 4, 0, 16, 0));
        wait_idle();
`ifdef CONSTANT_TIME_COMPARE_EN
        attempt(8'h19, 8'h18, 8'h19, 1'b1, mk(0, 1, 3, 1, 16, 0));
`else
        attempt(8'h19, 8'h18, 8'h19, 1'b1, mk(0, 1, 0, 1, 4, 0));
`endif
        wait_idle();

        // Mismatch on the last digit only; the second failure locks out.
        attempt(8'h19, 8'h59, 8'h19, 1'b1, mk(0, 0, 3, 0, 16, LOCK));
        poke_lockout();
        wait_idle();

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
